// File: rtl/execute_cycle_if.sv
// E-stage inputs and registered M-stage outputs of the execute stage.
// The master side is the upstream/decode driver; the slave side is execute_cycle.
interface execute_cycle_if;
  logic        REGWRT_E_i;
  logic [1:0]  RSLTSRC_E_i;
  logic        MEMWRT_E_i;
  logic        JUMP_E_i;
  logic        BRANCH_E_i;
  logic [2:0]  BRTYPE_E_i;
  logic [3:0]  ALUCTRL_E_i;
  logic        ALUSRC_E_i;
  logic [31:0] RD1_E_i;
  logic [31:0] RD2_E_i;
  logic [31:0] PC_E_i;
  logic [31:0] IMM_E_i;
  logic [31:0] PCPLUS4_E_i;
  logic [4:0]  RD_E_i;
  logic [1:0]  FWDA_E_i;
  logic [1:0]  FWDB_E_i;
  logic [31:0] RSLT_W_i;

  logic        REGWRT_M_o;
  logic [1:0]  RSLTSRC_M_o;
  logic        MEMWRT_M_o;
  logic [31:0] ALURSLT_M_o;
  logic [31:0] WRTDATA_M_o;
  logic [31:0] IMM_M_o;
  logic [31:0] PCPLUS4_M_o;
  logic [4:0]  RD_M_o;
  logic        PCSRC_E_o;
  logic [31:0] PCTARGET_E_o;

  modport master (
    output REGWRT_E_i, RSLTSRC_E_i, MEMWRT_E_i, JUMP_E_i, BRANCH_E_i, BRTYPE_E_i,
           ALUCTRL_E_i, ALUSRC_E_i, RD1_E_i, RD2_E_i, PC_E_i, IMM_E_i,
           PCPLUS4_E_i, RD_E_i, FWDA_E_i, FWDB_E_i, RSLT_W_i,
    input  REGWRT_M_o, RSLTSRC_M_o, MEMWRT_M_o, ALURSLT_M_o, WRTDATA_M_o,
           IMM_M_o, PCPLUS4_M_o, RD_M_o, PCSRC_E_o, PCTARGET_E_o
  );

  modport slave (
    input  REGWRT_E_i, RSLTSRC_E_i, MEMWRT_E_i, JUMP_E_i, BRANCH_E_i, BRTYPE_E_i,
           ALUCTRL_E_i, ALUSRC_E_i, RD1_E_i, RD2_E_i, PC_E_i, IMM_E_i,
           PCPLUS4_E_i, RD_E_i, FWDA_E_i, FWDB_E_i, RSLT_W_i,
    output REGWRT_M_o, RSLTSRC_M_o, MEMWRT_M_o, ALURSLT_M_o, WRTDATA_M_o,
           IMM_M_o, PCPLUS4_M_o, RD_M_o, PCSRC_E_o, PCTARGET_E_o
  );
endinterface

// File: rtl/execute_cycle.sv
// RV32 execute stage: operand forwarding, ALU, branch resolution and the E->M
// pipeline register (one-cycle latency, no stall, async active-low clear).
module execute_cycle (
  input  logic          clk_i,
  input  logic          rst_i,
  execute_cycle_if.slave ex
);
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic        regwrt;
    logic [1:0]  rsltsrc;
    logic        memwrt;
    logic [31:0] alu_rslt;
    logic [31:0] wrt_data;
    logic [31:0] imm;
    logic [31:0] pcplus4;
    logic [4:0]  rd;
  } m_stage_t;

  m_stage_t    m_d, m_q;
  alu_op_e     op;
  logic [31:0] src_a, fwd_b, src_b, alu_rslt;
  logic [4:0]  shamt;
  logic        br_eq, br_lt, br_ltu, br_true;

  // Forward source 2 is the registered M-stage result, i.e. the instruction one ahead.
  always_comb begin
    src_a = ex.RD1_E_i;
    case (ex.FWDA_E_i)
      2'd1:    src_a = ex.RSLT_W_i;
      2'd2:    src_a = m_q.alu_rslt;
      default: src_a = ex.RD1_E_i;
    endcase
  end

  always_comb begin
    fwd_b = ex.RD2_E_i;
    case (ex.FWDB_E_i)
      2'd1:    fwd_b = ex.RSLT_W_i;
      2'd2:    fwd_b = m_q.alu_rslt;
      default: fwd_b = ex.RD2_E_i;
    endcase
  end

  assign src_b = ex.ALUSRC_E_i ? ex.IMM_E_i : fwd_b;
  assign shamt = src_b[4:0];
  assign op    = alu_op_e'(ex.ALUCTRL_E_i);

  always_comb begin
    alu_rslt = '0;
    case (op)
      ALU_ADD:  alu_rslt = src_a + src_b;
      ALU_SUB:  alu_rslt = src_a - src_b;
      ALU_AND:  alu_rslt = src_a & src_b;
      ALU_OR:   alu_rslt = src_a | src_b;
      ALU_XOR:  alu_rslt = src_a ^ src_b;
      ALU_SLT:  alu_rslt = {31'd0, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: alu_rslt = {31'd0, src_a < src_b};
      ALU_SLL:  alu_rslt = src_a << shamt;
      ALU_SRL:  alu_rslt = src_a >> shamt;
      ALU_SRA:  alu_rslt = $unsigned($signed(src_a) >>> shamt);
      default:  alu_rslt = '0;
    endcase
  end

  // Branches compare the two register operands; the immediate only feeds the ALU/target.
  assign br_eq  = (src_a == fwd_b);
  assign br_lt  = ($signed(src_a) < $signed(fwd_b));
  assign br_ltu = (src_a < fwd_b);

  always_comb begin
    br_true = 1'b0;
    case (ex.BRTYPE_E_i)
      3'b000:  br_true = br_eq;
      3'b001:  br_true = ~br_eq;
      3'b100:  br_true = br_lt;
      3'b101:  br_true = ~br_lt;
      3'b110:  br_true = br_ltu;
      3'b111:  br_true = ~br_ltu;
      default: br_true = 1'b0;
    endcase
  end

  assign ex.PCSRC_E_o    = ex.JUMP_E_i | (ex.BRANCH_E_i & br_true);
  assign ex.PCTARGET_E_o = ex.PC_E_i + ex.IMM_E_i;

  // Store data is the forwarded rs2 so a just-produced value reaches memory.
  always_comb begin
    m_d          = '0;
    m_d.regwrt   = ex.REGWRT_E_i;
    m_d.rsltsrc  = ex.RSLTSRC_E_i;
    m_d.memwrt   = ex.MEMWRT_E_i;
    m_d.alu_rslt = alu_rslt;
    m_d.wrt_data = fwd_b;
    m_d.imm      = ex.IMM_E_i;
    m_d.pcplus4  = ex.PCPLUS4_E_i;
    m_d.rd       = ex.RD_E_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) m_q <= '0;
    else        m_q <= m_d;
  end

  assign ex.REGWRT_M_o  = m_q.regwrt;
  assign ex.RSLTSRC_M_o = m_q.rsltsrc;
  assign ex.MEMWRT_M_o  = m_q.memwrt;
  assign ex.ALURSLT_M_o = m_q.alu_rslt;
  assign ex.WRTDATA_M_o = m_q.wrt_data;
  assign ex.IMM_M_o     = m_q.imm;
  assign ex.PCPLUS4_M_o = m_q.pcplus4;
  assign ex.RD_M_o      = m_q.rd;
endmodule

// File: doc/execute_cycle.md
EXECUTE_CYCLE -- requirements
Module: execute_cycle

Interface
No parameters.
REQ-001 clk_i  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst_i  in  1  reset, asynchronous, active-low.
REQ-003 REGWRT_E_i  in  1  register-file write enable from decode.
REQ-004 RSLTSRC_E_i  in  2  writeback source select: 0 ALU, 1 memory, 2 PC+4, 3 immediate.
REQ-005 MEMWRT_E_i  in  1  data-memory write enable.
REQ-006 JUMP_E_i  in  1  unconditional jump (JAL).
REQ-007 BRANCH_E_i  in  1  conditional branch instruction.
REQ-008 BRTYPE_E_i  in  3  branch funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
REQ-009 ALUCTRL_E_i  in  4  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA.
REQ-010 ALUSRC_E_i  in  1  ALU operand B select: 0 forwarded rs2, 1 immediate.
REQ-011 RD1_E_i  in  32  rs1 value read in decode.
REQ-012 RD2_E_i  in  32  rs2 value read in decode.
REQ-013 PC_E_i  in  32  instruction PC.
REQ-014 IMM_E_i  in  32  sign-extended immediate.
REQ-015 PCPLUS4_E_i  in  32  PC+4.
REQ-016 RD_E_i  in  5  destination register index.
REQ-017 FWDA_E_i  in  2  rs1 forward select: 0 RD1_E_i, 1 RSLT_W_i, 2 ALURSLT_M_o.
REQ-018 FWDB_E_i  in  2  rs2 forward select, same encoding.
REQ-019 RSLT_W_i  in  32  final writeback result.
REQ-020 REGWRT_M_o, RSLTSRC_M_o(2), MEMWRT_M_o  out  registered control for memory stage.
REQ-021 ALURSLT_M_o  out  32  registered ALU result (data-memory address).
REQ-022 WRTDATA_M_o  out  32  registered forwarded rs2 (store data).
REQ-023 IMM_M_o, PCPLUS4_M_o  out  32 each  registered pass-through.
REQ-024 RD_M_o  out  5  registered destination index.
REQ-025 PCSRC_E_o  out  1  combinational redirect request.
REQ-026 PCTARGET_E_o  out  32  combinational PC_E_i + IMM_E_i, modulo 2^32.

Function
REQ-027 SrcA = mux(FWDA_E_i); fwdB = mux(FWDB_E_i); select value 3 SHALL behave as 0.
REQ-028 SrcB = ALUSRC_E_i ? IMM_E_i : fwdB.
REQ-029 ADD/SUB wrap modulo 2^32; SLT signed and SLTU unsigned, result 0/1 zero-extended; shifts use SrcB[4:0] only; SRA sign-fills; ALUCTRL codes 10-15 yield 0.
REQ-030 Branch compare SHALL use SrcA and fwdB (never the immediate); undefined BRTYPE codes (010, 011) SHALL evaluate not-taken.
REQ-031 PCSRC_E_o = JUMP_E_i | (BRANCH_E_i & condition true); both flags set: jump wins (PCSRC=1).
REQ-032 On every rising edge out of reset, all M-stage outputs SHALL load this cycle's values: one-cycle latency, no stall or enable.
REQ-033 WRTDATA_M_o SHALL capture fwdB, not RD2_E_i, so a store whose data arrives by forwarding writes the fresh value.
REQ-034 ALURSLT_M_o used as forward source is the pre-edge register value: forwarding from an instruction one ahead is valid in the same cycle.
REQ-035 Flushing the E stage is the upstream register's job; this block carries no flush input.

Reset
REQ-036 rst_i low SHALL immediately clear every registered output to 0 regardless of clk_i (bubble: REGWRT_M_o=0, MEMWRT_M_o=0).
REQ-037 Reset asserted mid-stream SHALL discard the in-flight instruction; first edge after release captures current inputs.
REQ-038 PCSRC_E_o and PCTARGET_E_o stay combinational during reset.

Verification
REQ-039 Reset: drive nonzero inputs, pulse rst_i low between edges -> all M outputs 0 at once, no clock needed.
REQ-040 ALU: SrcA=0x8000_0000, SrcB=1, SRA -> 0xC000_0000; SLT -> 1; SLTU -> 0; ADD 0xFFFF_FFFF+1 -> 0 one edge later.
REQ-041 Forwarding: RD1=5, RSLT_W=7, ALURSLT_M_o=9; FWDA=0/1/2/3 with ADD, ALUSRC=1, IMM=0 -> 5/7/9/5.
REQ-042 Branch: SrcA=0xFFFF_FFFF, fwdB=1 -> BLT taken, BLTU not taken, BEQ with ALUSRC=1 compares fwdB not IMM; PC=0x100, IMM=0xFFFF_FFF0 -> target 0xF0.
REQ-043 Store forwarding: FWDB=2, ALUSRC=1, MEMWRT=1 -> WRTDATA_M_o equals prior ALURSLT_M_o, not RD2_E_i.
REQ-044 Jump+branch together with false condition -> PCSRC_E_o=1; undefined BRTYPE with BRANCH=1 -> 0.
